// File: rtl/executor_arbiter_pkg.sv
// Shared types and helpers for the executor arbiter: FSM state encoding and
// the width of a requester ID.
package executor_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    // A requester ID needs at least one bit, even for a degenerate count.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/executor_arbiter_if.sv
// Requester-side handshakes plus the shared Executor operand/result wires.
// The arbiter takes the slave view; requesters and the Executor sit on master.
interface executor_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_op1;
    logic [NREQ*WIDTH-1:0] req_op2;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [WIDTH-1:0]      exe_operand1;
    logic [WIDTH-1:0]      exe_operand2;
    logic [WIDTH-1:0]      exe_result;

    modport slave (
        input  req_valid, req_op1, req_op2, rsp_ready, exe_result,
        output req_ready, rsp_valid, rsp_data, exe_operand1, exe_operand2
    );

    modport master (
        output req_valid, req_op1, req_op2, rsp_ready, exe_result,
        input  req_ready, rsp_valid, rsp_data, exe_operand1, exe_operand2
    );

endinterface

// File: rtl/executor_arbiter_rr.sv
// Request arbiter: round-robin when EXECUTOR_ARB_RR_EN is defined, otherwise
// fixed priority with the lowest index winning. Grant outputs are combinational.
module rr_arbiter
    import executor_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_enable,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_grant_idx
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

`ifdef EXECUTOR_ARB_RR_EN
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_cand;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'(v % NREQ);
    endfunction

    // Search starts at the pointer and wraps, so the last winner goes last.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_cand = wrap_idx(int'(r_ptr) + off);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= wrap_idx(int'(o_grant_idx) + 1);
        end
    end
`else
    logic w_unused_fixed;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found = 1'b1;
                w_idx   = ID_W'(i);
            end
        end
    end

    // Fixed priority keeps no state, so the clocking inputs go unused.
    assign w_unused_fixed = clk ^ reset ^ i_advance;
`endif

    assign o_grant     = (i_enable && w_found) ? (NREQ'(1) << w_idx) : '0;
    assign o_grant_idx = w_idx;

endmodule

// File: rtl/executor_arbiter.sv
// Shares one registered-result Executor adder among NREQ requesters, one
// operation at a time. Define EXECUTOR_ARB_RR_EN for round-robin arbitration.
module executor_arbiter
    import executor_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic               clk,
    input  logic               reset,
    executor_arbiter_if.slave  bus
);

    localparam int ID_W = id_width(NREQ);

    state_t           r_state;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_rsp_data;
    logic [NREQ-1:0]  r_rsp_valid;

    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_rsp_accept;
    logic             w_slot;
    logic             w_take;
    logic [WIDTH-1:0] w_sel_op1;
    logic [WIDTH-1:0] w_sel_op2;
    logic [NREQ-1:0]  w_id_onehot;

    // A grant slot opens in IDLE, or in RESP on the very cycle the owner
    // takes its result; stray rsp_ready bits on other ports are ignored.
    assign w_rsp_accept = (r_state == RESP) && bus.rsp_ready[r_id];
    assign w_slot       = (r_state == IDLE) || w_rsp_accept;
    assign w_take       = |w_grant;

    assign w_sel_op1   = bus.req_op1[w_grant_idx*WIDTH +: WIDTH];
    assign w_sel_op2   = bus.req_op2[w_grant_idx*WIDTH +: WIDTH];
    assign w_id_onehot = NREQ'(1) << r_id;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req       (bus.req_valid),
        .i_enable    (w_slot),
        .i_advance   (w_take),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        // NOTE: state and output registers use non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state     <= IDLE;
            r_id        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_op1   <= w_sel_op1;
                        r_op2   <= w_sel_op2;
                        r_id    <= w_grant_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_rsp_data  <= bus.exe_result;
                    r_rsp_valid <= w_id_onehot;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_accept) begin
                        r_rsp_valid <= '0;
                        if (w_take) begin
                            r_op1   <= w_sel_op1;
                            r_op2   <= w_sel_op2;
                            r_id    <= w_grant_idx;
                            r_state <= EXEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.exe_operand1 = r_op1;
    assign bus.exe_operand2 = r_op2;

endmodule

// File: tb/tb_executor_arbiter.sv
// Directed bench for executor_arbiter with a registered-adder Executor model;
// expectations follow the build's arbitration mode (EXECUTOR_ARB_RR_EN).
module tb_executor_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    executor_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    executor_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-cycle Executor: result registered one edge after the operands.
    always @(posedge clk) bus.exe_result <= bus.exe_operand1 + bus.exe_operand2;

    typedef struct {
        int          id;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        bus.req_op1[id*WIDTH +: WIDTH] = a;
        bus.req_op2[id*WIDTH +: WIDTH] = b;
    endtask

    // Requester hold rule, observed between consecutive falling edges.
    logic [NREQ-1:0]       m_valid;
    logic [NREQ-1:0]       m_ready;
    logic [NREQ*WIDTH-1:0] m_op1;
    logic [NREQ*WIDTH-1:0] m_op2;
    logic                  m_rst = 1'b1;

    always @(negedge clk) begin
        if (!reset && !m_rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_valid[i] && !m_ready[i]) begin
                    assert (bus.req_valid[i] &&
                            bus.req_op1[i*WIDTH +: WIDTH] == m_op1[i*WIDTH +: WIDTH] &&
                            bus.req_op2[i*WIDTH +: WIDTH] == m_op2[i*WIDTH +: WIDTH])
                    else $error("requester %0d dropped or changed a pending request", i);
                end
            end
        end
        m_valid <= bus.req_valid;
        m_ready <= bus.req_ready;
        m_op1   <= bus.req_op1;
        m_op2   <= bus.req_op2;
        m_rst   <= reset;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order [5];
`ifdef EXECUTOR_ARB_RR_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        vecs[0] = '{2, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
        vecs[2] = '{1, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789};
        vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[4] = '{2, 32'hDEAD_0000, 32'h0000_BEEF, 32'hDEAD_BEEF};

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_op1   = '0;
        bus.req_op2   = '0;
        bus.rsp_ready = '0;
        repeat (3) next_cycle();

        check("reset_req_ready", bus.req_ready, '0);
        check("reset_rsp_valid", bus.rsp_valid, '0);
        check("reset_rsp_data", bus.rsp_data, '0);
        check("reset_operand1", bus.exe_operand1, '0);
        check("reset_operand2", bus.exe_operand2, '0);
        reset = 1'b0;

        // Single isolated requests: grant in cycle 0, result in cycle 3.
        for (int v = 0; v < 5; v++) begin
            next_cycle();
            bus.rsp_ready = '1;
            set_req(vecs[v].id, vecs[v].op1, vecs[v].op2);
            bus.req_valid = onehot(vecs[v].id);
            #1;
            check($sformatf("vec%0d_grant", v), bus.req_ready, onehot(vecs[v].id));
            next_cycle();
            bus.req_valid = '0;
            #1;
            check($sformatf("vec%0d_exec_ready", v), bus.req_ready, '0);
            check($sformatf("vec%0d_operand1", v), bus.exe_operand1, vecs[v].op1);
            check($sformatf("vec%0d_operand2", v), bus.exe_operand2, vecs[v].op2);
            next_cycle();
            check($sformatf("vec%0d_wait_valid", v), bus.rsp_valid, '0);
            next_cycle();
            check($sformatf("vec%0d_rsp_valid", v), bus.rsp_valid, onehot(vecs[v].id));
            check($sformatf("vec%0d_rsp_data", v), bus.rsp_data, vecs[v].sum);
            next_cycle();
            check($sformatf("vec%0d_idle_valid", v), bus.rsp_valid, '0);
        end

        // Contention: all four requesters held valid, grants 3 cycles apart.
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * (i + 1), i);
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        #1;
        check("cont_grant0", bus.req_ready, onehot(order[0]));
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            check($sformatf("cont%0d_exec_ready", k), bus.req_ready, '0);
            next_cycle();
            check($sformatf("cont%0d_wait_ready", k), bus.req_ready, '0);
            next_cycle();
            check($sformatf("cont%0d_rsp_valid", k), bus.rsp_valid, onehot(order[k]));
            check($sformatf("cont%0d_rsp_data", k), bus.rsp_data,
                  32'h100 * (order[k] + 1) + order[k]);
            if (k < 4) check($sformatf("cont_grant%0d", k + 1), bus.req_ready, onehot(order[k + 1]));
        end
        reset         = 1'b1;
        bus.req_valid = '0;
        next_cycle();
        reset = 1'b0;

        // Response stall on port 1 while requester 3 waits.
        set_req(1, 32'd7, 32'd8);
        bus.req_valid = 4'b0010;
        #1;
        check("stall_grant1", bus.req_ready, 4'b0010);
        next_cycle();
        set_req(3, 32'd100, 32'd23);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 4'b1101;
        #1;
        check("stall_exec_ready", bus.req_ready, '0);
        next_cycle();
        check("stall_wait_ready", bus.req_ready, '0);
        for (int s = 0; s < 5; s++) begin
            next_cycle();
            check($sformatf("stall%0d_rsp_valid", s), bus.rsp_valid, 4'b0010);
            check($sformatf("stall%0d_rsp_data", s), bus.rsp_data, 32'd15);
            check($sformatf("stall%0d_req_ready", s), bus.req_ready, '0);
        end
        next_cycle();
        bus.rsp_ready = '1;
        #1;
        check("stall_release_grant3", bus.req_ready, 4'b1000);
        next_cycle();
        bus.req_valid = '0;
        #1;
        check("stall_exec3_operand1", bus.exe_operand1, 32'd100);
        check("stall_exec3_rsp_valid", bus.rsp_valid, '0);
        next_cycle();
        next_cycle();
        check("stall_rsp3_valid", bus.rsp_valid, 4'b1000);
        check("stall_rsp3_data", bus.rsp_data, 32'd123);
        next_cycle();

        // Ready on the wrong port must not complete the response.
        set_req(0, 32'd1, 32'd2);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 4'b0010;
        #1;
        check("wrong_grant0", bus.req_ready, 4'b0001);
        next_cycle();
        set_req(2, 32'd9, 32'd9);
        bus.req_valid = 4'b0100;
        next_cycle();
        next_cycle();
        check("wrong_rsp_valid_a", bus.rsp_valid, 4'b0001);
        check("wrong_rsp_data_a", bus.rsp_data, 32'd3);
        check("wrong_req_ready_a", bus.req_ready, '0);
        next_cycle();
        check("wrong_rsp_valid_b", bus.rsp_valid, 4'b0001);
        check("wrong_req_ready_b", bus.req_ready, '0);
        next_cycle();
        bus.rsp_ready = 4'b0001;
        #1;
        check("wrong_accept_grant2", bus.req_ready, 4'b0100);
        next_cycle();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        next_cycle();
        next_cycle();
        check("wrong_rsp2_valid", bus.rsp_valid, 4'b0100);
        check("wrong_rsp2_data", bus.rsp_data, 32'd18);
        next_cycle();

        // Reset during WAIT with the request held across it.
        set_req(2, 32'd40, 32'd2);
        bus.req_valid = 4'b0100;
        #1;
        check("rstw_grant", bus.req_ready, 4'b0100);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check("rstw_rsp_valid", bus.rsp_valid, '0);
        check("rstw_rsp_data", bus.rsp_data, '0);
        check("rstw_operand1", bus.exe_operand1, '0);
        check("rstw_operand2", bus.exe_operand2, '0);
        check("rstw_regrant", bus.req_ready, 4'b0100);
        next_cycle();
        bus.req_valid = '0;
        #1;
        check("rstw_exec_operand1", bus.exe_operand1, 32'd40);
        check("rstw_exec_rsp_valid", bus.rsp_valid, '0);
        next_cycle();
        check("rstw_wait_rsp_valid", bus.rsp_valid, '0);
        next_cycle();
        check("rstw_rsp_valid2", bus.rsp_valid, 4'b0100);
        check("rstw_rsp_data2", bus.rsp_data, 32'd42);
        next_cycle();
        check("rstw_idle_valid", bus.rsp_valid, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
